// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode constants and fetch FSM state type for the
// 16-bit single-issue core.
package cpu_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_INST_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUBI = 4'b0101;
  localparam logic [3:0] OP_BEQZ = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT_PEND,
    HALTED
  } fetch_state_t;

  // True when the opcode field marks the end of the program.
  function automatic logic is_halt(input logic [3:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter, one-entry instruction register and fetch
// FSM. Drives the combinational instruction memory and hands words to decode
// over a valid/ready handshake; squashes on branch redirects and stops after
// a halt word has been handed off.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INST_W   = DEFAULT_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              ir_valid,
  output logic [INST_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       instr_count
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              ir_free;
  logic              xfer;
  logic              fetch_is_halt;

  assign ir_free       = !ir_valid || ir_ready;
  assign xfer          = ir_valid && ir_ready;
  assign fetch_is_halt = is_halt(imem_inst[INST_W-1 -: 4]);
  assign imem_addr     = pc;

  // Fetch FSM: owns the PC, the instruction register, the handshake counter
  // and the registered status flags; a redirect outranks everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir_valid    <= 1'b0;
      ir          <= '0;
      ir_pc       <= '0;
      instr_count <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (xfer && instr_count != 16'hFFFF) begin
        instr_count <= instr_count + 16'd1;
      end

      unique case (state)
        IDLE, HALTED: begin
          if (start) begin
            state       <= RUN;
            pc          <= RESET_PC;
            instr_count <= '0;
            busy        <= 1'b1;
            halted      <= 1'b0;
          end
        end

        RUN: begin
          if (redirect_valid) begin
            pc       <= redirect_target;
            ir_valid <= 1'b0;
          end else if (ir_free) begin
            ir       <= imem_inst;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (fetch_is_halt) begin
              state <= HALT_PEND;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end

        HALT_PEND: begin
          if (redirect_valid) begin
            state    <= RUN;
            pc       <= redirect_target;
            ir_valid <= 1'b0;
          end else if (ir_ready) begin
            state    <= HALTED;
            ir_valid <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch controller for the 16-bit single-issue core. Drives the 8-bit address of the combinational instruction memory, holds the fetched word in a one-entry instruction register and hands it to decode over a valid/ready handshake. Accepts branch redirects from execute and stops fetching once a `halt` instruction has been handed off. Sits between instruction memory and the decode stage.

## Interface
- `ADDR_W`, 8, instruction address width (256 words).
- `INST_W`, 16, instruction width.
- `RESET_PC`, 0, PC loaded at reset and on every `start`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins execution at `RESET_PC`.
- `imem_addr`  out  ADDR_W  address to instruction memory; always equals the PC.
- `imem_inst`  in  INST_W  instruction word, combinational from `imem_addr`, same cycle.
- `ir_valid`  out  1  instruction register holds a word for decode.
- `ir`  out  INST_W  instruction word.
- `ir_pc`  out  ADDR_W  address `ir` was fetched from.
- `ir_ready`  in  1  decode accepts `ir` this cycle.
- `redirect_valid`  in  1  execute redirects fetch (taken `beqz`).
- `redirect_target`  in  ADDR_W  new PC, already resolved by execute.
- `busy`  out  1  state is RUN or HALT_PEND.
- `halted`  out  1  state is HALTED.
- `instr_count`  out  16  handshakes completed since the last `start`; saturates at 0xFFFF.

## Operation
- Halt detection: `imem_inst[15:12] == OP_HALT (4'b1100)`.
- States:
  - IDLE: reset state. `start` leads to RUN, loads PC from `RESET_PC` and clears `instr_count`.
  - RUN: fetches while the instruction register is free.
  - HALT_PEND: the halt word has been fetched and is not yet accepted. No further fetches.
  - HALTED: terminal until `start` or reset. `start` leads to RUN with the same loads as from IDLE.
- The instruction register is free when `!ir_valid || ir_ready`.
- RUN with a free register and no redirect:
  - `ir <= imem_inst`, `ir_pc <= PC`, `ir_valid <= 1`, `PC <= PC + 1`.
  - PC is modulo 2^ADDR_W, so 255 wraps to 0.
  - If the fetched word is a halt, also go to HALT_PEND and leave PC unchanged.
- RUN with the register not free: hold `ir`, `ir_pc`, `ir_valid` and PC.
- HALT_PEND: when `ir_ready`, set `ir_valid <= 0` and go to HALTED.
- Handshake: a transfer occurs when `ir_valid && ir_ready`. Each transfer increments `instr_count`, saturating at 0xFFFF.
- `redirect_valid` in RUN or HALT_PEND has priority over every other action in that cycle:
  - `PC <= redirect_target`, `ir_valid <= 0` (the held word is squashed), state goes to RUN, and nothing is fetched that cycle.
  - A transfer in the same cycle still counts.
- `redirect_valid` in IDLE or HALTED is ignored.
- `start` in RUN or HALT_PEND is ignored.
- `ir` and `ir_pc` hold their last value when `ir_valid` is 0.

## Timing
- Reset values, applied asynchronously:
  - state IDLE, PC = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - `ir_valid` 0, `ir` 0, `ir_pc` 0, `instr_count` 0, `busy` 0, `halted` 0.
- `start` sampled at edge N: first `ir_valid` at edge N+1 with `ir_pc` = `RESET_PC`.
- Throughput: one instruction per cycle while `ir_ready` is held at 1.
- Redirect sampled at edge N: `ir_valid` is 0 after edge N; the word from the target is valid after edge N+1. Penalty is one bubble.
- Halt accepted at edge N: `halted` is 1 and `busy` is 0 after edge N.
- Reset asserted mid-operation returns to IDLE immediately; no drain.
- All outputs are registered except `imem_addr`, which is the PC register itself.

## Structure
- Shared package `cpu_pkg` holds:
  - `ADDR_W` and `INST_W` defaults.
  - The opcode constants: `OP_ADD 4'b0000`, `OP_ADDI 4'b0100`, `OP_SUBI 4'b0101`, `OP_BEQZ 4'b1001`, `OP_HALT 4'b1100`.
  - The `fetch_state_t` enum {IDLE, RUN, HALT_PEND, HALTED}.
- Single module. No sub-module; the PC, the instruction register and the FSM live together.

## Test plan
All scenarios load the 10-word Fibonacci program into the memory model (halt at address 9).

- **Free-running fetch:** `start` with `ir_ready`=1 and no redirects. Required: `ir_pc` runs 0,1,…,9 on consecutive cycles, then HALTED, with `instr_count`=10.
- **Decode backpressure:** `ir_ready`=0 for 3 cycles at `ir_pc`=4. Required: `ir`, `ir_pc` and `imem_addr`=5 are held, and there is no skip or duplicate after release.
- **Redirect mid-stream:** redirect to 4 while `ir_pc`=9 is valid and unaccepted. Required:
  - the halt word is squashed and the state returns to RUN;
  - the next valid word has `ir_pc`=4 exactly one cycle later.
- **Redirect coinciding with a transfer:** redirect while `ir_ready`=1. Required: `instr_count` increments and the squashed word is not re-issued.
- **PC wrap-around:** `RESET_PC`=254, memory holds `OP_ADD` words at 254, 255 and 0, and a halt at 1. Required: `ir_pc` sequence 254, 255, 0, 1, then HALTED.
- **Reset and restart:** `rst_n` low during RUN. Required: all reset values appear immediately; `start` after release restarts at 0 with `instr_count` cleared. `start` in HALTED also restarts at 0.
